load_store_unit: RTL and testbench
==================================

# load_store_unit

Initiator-side load/store unit that turns RV32 byte-addressed load/store requests from the core into word accesses on the data `memory` port (`address`/`wdata`/`rdata`/`MemRead`/`MemWrite`). It handles byte and halfword selection, sign/zero extension and sub-word stores. Sub-word stores use read-modify-write, because the memory has no byte enables. It sits between the execute stage and the data memory and returns exactly one response per accepted request.

## Interface
- `WORD_ADDR_BITS`, default 5: word-index width; the memory holds 2^WORD_ADDR_BITS words.

- `clk`  in  1  clock; all state updates on the rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `req_valid`  in  1  core presents a request
- `req_ready`  out  1  high only in IDLE; a request is accepted on the edge where `req_valid && req_ready`
- `req_write`  in  1  1 = store, 0 = load
- `req_funct3`  in  3  RV32 funct3 encoding:
  - loads: 000 lb, 001 lh, 010 lw, 100 lbu, 101 hu
  - stores: 000 sb, 001 sh, 010 sw
- `req_addr`  in  32  byte address
- `req_wdata`  in  32  store data; the low byte or halfword is used for sb/sh
- `resp_valid`  out  1  one-cycle pulse; the response is complete
- `resp_rdata`  out  32  load result; 0 for stores and errors
- `resp_err`  out  1  qualified by `resp_valid`; request was rejected
- `mem_address`  out  32  word index = `{0, addr[WORD_ADDR_BITS+1:2]}`
- `mem_wdata`  out  32  full word to write
- `mem_rdata`  in  32  memory read data; valid only in the cycle after `MemRead` is sampled
- `MemRead`  out  1  read strobe
- `MemWrite`  out  1  write strobe; never asserted together with `MemRead`

## Operation
- States: IDLE, RD, CAP, WR, RESP. `MemRead`, `MemWrite`, `req_ready` and `resp_valid` are decoded from state only (Moore outputs).
- **IDLE**
  - On acceptance, latch `write`, `funct3`, `addr` and `wdata`.
  - Classify the request as an error if any of the following holds, and go to RESP with `err=1`. No memory access is made.
    - Illegal funct3: 011/110/111 for any access, or 100/101 for a store.
    - Halfword access with `addr[0]=1`.
    - Word access with `addr[1:0]≠0`.
    - `addr[31:WORD_ADDR_BITS+2]≠0` (out of range).
  - Otherwise: sw goes to WR; loads, sb and sh go to RD.
- **RD**: `MemRead=1`, `mem_address` = latched word index. Next state: CAP.
- **CAP**: sample `mem_rdata`.
  - Load: select lane(s) by `addr[1:0]` (little-endian), extend per funct3 (signed for lb/lh, zero for lbu/lhu, passthrough for lw), register into `resp_rdata`, go to RESP.
  - sb/sh: merge the store byte or halfword into the sampled word at lane `addr[1:0]`, register it as the write word, go to WR.
- **WR**: `MemWrite=1`, `mem_wdata` = merged word, or `req_wdata` for sw. Next state: RESP.
- **RESP**: `resp_valid=1` for exactly one cycle. Next state: IDLE.
- `mem_address` holds the latched word index in RD, CAP and WR, and is 0 otherwise. `mem_wdata` is 0 outside WR.
- `resp_rdata` and `resp_err` are held until the next RESP.

## Timing
- Reset values: state = IDLE, `req_ready=1`, `resp_valid=0`, `resp_err=0`, `resp_rdata=0`, `MemRead=0`, `MemWrite=0`, `mem_address=0`, `mem_wdata=0`.
- Latency is counted from the acceptance edge (edge 0) to the cycle in which `resp_valid` is high:
  - lw/lh/lb/lhu/lbu: 3 cycles (RD, CAP, RESP).
  - sw: 2 cycles (WR, RESP).
  - sb/sh: 4 cycles (RD, CAP, WR, RESP).
  - error: 1 cycle.
- `req_ready=0` from the cycle after acceptance through RESP. A `req_valid` arriving while busy is not accepted; the core holds it.
- The earliest next acceptance is the cycle after RESP (IDLE).
- Back-to-back lw requests give 1 response per 4 cycles.
- Reset asserted mid-operation returns the FSM to IDLE immediately and asynchronously, dropping `MemRead`/`MemWrite` in the same cycle.
  - An RMW interrupted before its WR edge leaves memory unchanged.
  - No response is issued for the aborted request.
- `mem_rdata` is ignored in every state except CAP; the memory drives X there when idle.

## Test plan
- **Word write/read.** sw `addr=0x0000_0010`, `wdata=0xDEAD_BEEF`: expect `MemWrite` high one cycle with `mem_address=4`, then `resp_valid` 2 cycles after acceptance. Then lw `0x10`: expect `resp_rdata=0xDEAD_BEEF` 3 cycles after acceptance, `resp_err=0`.
- **Byte extension.** With word 4 holding `0xDEAD_BEEF`:
  - lb `0x13` → `0xFFFF_FFDE`
  - lbu `0x13` → `0x0000_00DE`
  - lh `0x10` → `0xFFFF_BEEF`
  - lhu `0x12` → `0x0000_DEAD`
- **Sub-word RMW.** sb `0x11`, `wdata=0x0000_0055`: expect RD, CAP, WR sequence with `mem_wdata=0xDEAD_55EF`; a following lw `0x10` → `0xDEAD_55EF`. Then sh `0x12`, `wdata=0x1234` → word reads `0x1234_55EF`.
- **Errors.** Each of the following → `resp_err=1`, `resp_rdata=0`, response 1 cycle after acceptance, `MemRead`/`MemWrite` never asserted, memory contents unchanged:
  - lw `0x11`
  - lh `0x13`
  - sb with `funct3=100`
  - funct3 `011`
  - lw `0x80` (with `WORD_ADDR_BITS=5`)
- **Handshake.** Hold `req_valid` continuously with two queued lw requests: expect `req_ready` low from the cycle after acceptance through RESP; the second request is accepted in the first IDLE cycle after RESP; exactly two `resp_valid` pulses.
- **Reset mid-RMW.** Deassert `rst_n` during CAP of an sb: expect outputs at their reset values immediately, no `MemWrite` pulse, the original word unchanged on a subsequent lw, and no `resp_valid` for the aborted store.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Core-side request/response bundle and word-wide data-memory bundle for load_store_unit.
// Master drives the request (or memory command); slave answers.
interface load_store_unit_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;

   modport master (
      output req_valid, req_write, req_funct3, req_addr, req_wdata,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );
   modport slave (
      input  req_valid, req_write, req_funct3, req_addr, req_wdata,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

interface load_store_unit_mem_if;
   logic [31:0] mem_address;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        MemRead;
   logic        MemWrite;

   modport master (
      output mem_address, mem_wdata, MemRead, MemWrite,
      input  mem_rdata
   );
   modport slave (
      input  mem_address, mem_wdata, MemRead, MemWrite,
      output mem_rdata
   );
endinterface

// File: rtl/load_store_unit.sv
// RV32 load/store unit: byte-addressed core requests to word-wide memory accesses,
// with lane extraction, sign/zero extension and read-modify-write for sb/sh.
module load_store_unit #(
   parameter int unsigned WORD_ADDR_BITS = 5
) (
   input logic                   clk,
   input logic                   rst_n,
   load_store_unit_if.slave      core,
   load_store_unit_mem_if.master mem
);

   typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} state_e;

   state_e                      state_q;
   logic                        write_q;
   logic [2:0]                  funct3_q;
   logic [WORD_ADDR_BITS+1:0]   addr_q;
   logic [31:0]                 wword_q;
   logic [31:0]                 rdata_q;
   logic                        err_q;

   logic                        req_err;
   logic [4:0]                  shamt;
   logic [31:0]                 lane;
   logic [31:0]                 load_val;
   logic [31:0]                 mask;
   logic [31:0]                 merge_val;

   always_comb begin
      req_err = 1'b0;
      unique case (core.req_funct3)
         3'b000, 3'b001, 3'b010: req_err = 1'b0;
         3'b100, 3'b101:         req_err = core.req_write;
         default:                req_err = 1'b1;
      endcase
      if (core.req_funct3[1:0] == 2'b01 && core.req_addr[0])
         req_err = 1'b1;
      if (core.req_funct3[1:0] == 2'b10 && core.req_addr[1:0] != 2'b00)
         req_err = 1'b1;
      if ((core.req_addr >> (WORD_ADDR_BITS + 2)) != '0)
         req_err = 1'b1;
   end

   // Lane 0 of 'lane' is the addressed byte; for aligned lw the shift is zero.
   always_comb begin
      shamt     = {addr_q[1:0], 3'b000};
      lane      = mem.mem_rdata >> shamt;
      load_val  = lane;
      unique case (funct3_q)
         3'b000:  load_val = {{24{lane[7]}}, lane[7:0]};
         3'b001:  load_val = {{16{lane[15]}}, lane[15:0]};
         3'b100:  load_val = {24'h000000, lane[7:0]};
         3'b101:  load_val = {16'h0000, lane[15:0]};
         default: load_val = lane;
      endcase
      mask      = funct3_q[0] ? 32'h0000_FFFF : 32'h0000_00FF;
      merge_val = (mem.mem_rdata & ~(mask << shamt)) | ((wword_q & mask) << shamt);
   end

   assign core.req_ready  = (state_q == IDLE);
   assign core.resp_valid = (state_q == RESP);
   assign core.resp_rdata = rdata_q;
   assign core.resp_err   = err_q;
   assign mem.MemRead     = (state_q == RD);
   assign mem.MemWrite    = (state_q == WR);
   assign mem.mem_address = (state_q == RD || state_q == CAP || state_q == WR)
                            ? 32'(addr_q[WORD_ADDR_BITS+1:2]) : '0;
   assign mem.mem_wdata   = (state_q == WR) ? wword_q : '0;

   // wword_q holds req_wdata from acceptance, and is overwritten by the merged word for sb/sh.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         write_q  <= 1'b0;
         funct3_q <= '0;
         addr_q   <= '0;
         wword_q  <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (core.req_valid) begin
                  write_q  <= core.req_write;
                  funct3_q <= core.req_funct3;
                  addr_q   <= core.req_addr[WORD_ADDR_BITS+1:0];
                  wword_q  <= core.req_wdata;
                  if (req_err) begin
                     err_q   <= 1'b1;
                     rdata_q <= '0;
                     state_q <= RESP;
                  end else if (core.req_write && core.req_funct3 == 3'b010) begin
                     state_q <= WR;
                  end else begin
                     state_q <= RD;
                  end
               end
            end
            RD: state_q <= CAP;
            CAP: begin
               if (write_q) begin
                  wword_q <= merge_val;
                  state_q <= WR;
               end else begin
                  rdata_q <= load_val;
                  err_q   <= 1'b0;
                  state_q <= RESP;
               end
            end
            WR: begin
               rdata_q <= '0;
               err_q   <= 1'b0;
               state_q <= RESP;
            end
            RESP:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed scoreboard bench for load_store_unit against a 32-word behavioural memory.
module tb_load_store_unit;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int unsigned lat;
      int unsigned nrd;
      int unsigned nwr;
      logic [31:0] widx;
      logic [31:0] mw;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] mem_arr [32];
   logic [31:0] rdata_r;
   int unsigned cyc = 0;
   int unsigned n_checks = 0;
   int unsigned n_pass = 0;
   exp_t        q[$];
   bit          busy = 1'b0;
   int unsigned acc_cyc = 0;
   int unsigned nrd = 0;
   int unsigned nwr = 0;
   int unsigned mw_total = 0;
   int unsigned resp_total = 0;

   load_store_unit_if     core ();
   load_store_unit_mem_if m ();

   load_store_unit #(.WORD_ADDR_BITS(5)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .core (core),
      .mem  (m)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   always @(posedge clk) begin
      if (m.MemWrite) mem_arr[m.mem_address[4:0]] <= m.mem_wdata;
      if (m.MemRead) rdata_r <= mem_arr[m.mem_address[4:0]];
      else           rdata_r <= 'x;
   end
   assign m.mem_rdata = rdata_r;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   function automatic exp_t mk(logic [31:0] rd, logic er, int unsigned lat, int unsigned r,
                               int unsigned w, logic [31:0] widx, logic [31:0] mw);
      exp_t e;
      e.rdata = rd; e.err = er; e.lat = lat; e.nrd = r; e.nwr = w; e.widx = widx; e.mw = mw;
      return e;
   endfunction

   // Monitor: samples on the falling edge, tracks one transaction from acceptance to response.
   always @(negedge clk) begin
      if (!rst_n) begin
         busy = 1'b0;
      end else begin
         if (m.MemWrite) mw_total++;
         if (core.resp_valid) resp_total++;
         if (busy) begin
            chk("ready_busy", 32'(core.req_ready), 32'd0);
            if (m.MemRead) begin
               nrd++;
               if (q.size() != 0) chk("rd_addr", m.mem_address, q[0].widx);
            end
            if (m.MemWrite) begin
               nwr++;
               if (q.size() != 0) begin
                  chk("wr_addr", m.mem_address, q[0].widx);
                  chk("wr_data", m.mem_wdata, q[0].mw);
               end
            end
            if (core.resp_valid) begin
               chk("resp_has_exp", 32'(q.size() != 0), 32'd1);
               if (q.size() != 0) begin
                  exp_t e;
                  e = q.pop_front();
                  chk("rdata", core.resp_rdata, e.rdata);
                  chk("err", 32'(core.resp_err), 32'(e.err));
                  chk("latency", 32'(cyc - acc_cyc), 32'(e.lat));
                  chk("n_memread", 32'(nrd), 32'(e.nrd));
                  chk("n_memwrite", 32'(nwr), 32'(e.nwr));
               end
               busy = 1'b0;
            end
         end else begin
            chk("idle_quiet", {29'd0, core.resp_valid, m.MemRead, m.MemWrite}, 32'd0);
         end
         if (core.req_valid && core.req_ready) begin
            acc_cyc = cyc;
            busy    = 1'b1;
            nrd     = 0;
            nwr     = 0;
         end
      end
   end

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_ready"}, 32'(core.req_ready), 32'd1);
      chk({tag, "_strobes"}, {29'd0, core.resp_valid, m.MemRead, m.MemWrite}, 32'd0);
      chk({tag, "_err"}, 32'(core.resp_err), 32'd0);
      chk({tag, "_rdata"}, core.resp_rdata, 32'd0);
      chk({tag, "_addr"}, m.mem_address, 32'd0);
      chk({tag, "_wdata"}, m.mem_wdata, 32'd0);
   endtask

   task automatic send(input logic w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input exp_t e, output int unsigned acc_at);
      bit ok;
      ok = 1'b0;
      acc_at = 0;
      core.req_write  = w;
      core.req_funct3 = f3;
      core.req_addr   = a;
      core.req_wdata  = wd;
      core.req_valid  = 1'b1;
      q.push_back(e);
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (core.req_ready) begin
            acc_at = cyc;
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("accept_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 50 && q.size() != 0; i++) @(posedge clk);
      if (q.size() != 0) begin
         chk("resp_timeout", 32'(q.size()), 32'd0);
         q.delete();
      end
      @(posedge clk);
      #1;
   endtask

   task automatic req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input exp_t e);
      int unsigned t;
      send(w, f3, a, wd, e, t);
      core.req_valid = 1'b0;
      wait_done();
   endtask

   initial begin
      int unsigned acc1, acc2, mw_before, resp_before;
      exp_t        err_e;
      for (int i = 0; i < 32; i++) mem_arr[i] = 32'h0;
      mem_arr[8] = 32'hCAFE_F00D;
      core.req_valid  = 1'b0;
      core.req_write  = 1'b0;
      core.req_funct3 = 3'b000;
      core.req_addr   = 32'h0;
      core.req_wdata  = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // word write/read
      req(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, mk(32'h0, 1'b0, 2, 0, 1, 4, 32'hDEAD_BEEF));
      req(1'b0, 3'b010, 32'h10, 32'h0, mk(32'hDEAD_BEEF, 1'b0, 3, 1, 0, 4, 32'h0));
      // extension
      req(1'b0, 3'b000, 32'h13, 32'h0, mk(32'hFFFF_FFDE, 1'b0, 3, 1, 0, 4, 32'h0));
      req(1'b0, 3'b100, 32'h13, 32'h0, mk(32'h0000_00DE, 1'b0, 3, 1, 0, 4, 32'h0));
      req(1'b0, 3'b001, 32'h10, 32'h0, mk(32'hFFFF_BEEF, 1'b0, 3, 1, 0, 4, 32'h0));
      req(1'b0, 3'b101, 32'h12, 32'h0, mk(32'h0000_DEAD, 1'b0, 3, 1, 0, 4, 32'h0));
      // sub-word read-modify-write
      req(1'b1, 3'b000, 32'h11, 32'h0000_0055, mk(32'h0, 1'b0, 4, 1, 1, 4, 32'hDEAD_55EF));
      req(1'b0, 3'b010, 32'h10, 32'h0, mk(32'hDEAD_55EF, 1'b0, 3, 1, 0, 4, 32'h0));
      req(1'b1, 3'b001, 32'h12, 32'h0000_1234, mk(32'h0, 1'b0, 4, 1, 1, 4, 32'h1234_55EF));
      req(1'b0, 3'b010, 32'h10, 32'h0, mk(32'h1234_55EF, 1'b0, 3, 1, 0, 4, 32'h0));

      // rejected requests: no memory access, memory untouched
      err_e = mk(32'h0, 1'b1, 1, 0, 0, 0, 32'h0);
      req(1'b0, 3'b010, 32'h11, 32'h0, err_e);
      req(1'b0, 3'b001, 32'h13, 32'h0, err_e);
      req(1'b1, 3'b100, 32'h10, 32'hFFFF_FFFF, err_e);
      req(1'b0, 3'b011, 32'h10, 32'h0, err_e);
      req(1'b0, 3'b010, 32'h80, 32'h0, err_e);
      req(1'b0, 3'b010, 32'h10, 32'h0, mk(32'h1234_55EF, 1'b0, 3, 1, 0, 4, 32'h0));

      // back-to-back with req_valid held high
      resp_before = resp_total;
      send(1'b0, 3'b010, 32'h10, 32'h0, mk(32'h1234_55EF, 1'b0, 3, 1, 0, 4, 32'h0), acc1);
      send(1'b0, 3'b010, 32'h20, 32'h0, mk(32'hCAFE_F00D, 1'b0, 3, 1, 0, 8, 32'h0), acc2);
      core.req_valid = 1'b0;
      wait_done();
      chk("accept_spacing", 32'(acc2 - acc1), 32'd4);
      chk("b2b_resp_count", 32'(resp_total - resp_before), 32'd2);

      // reset during CAP of an sb
      mw_before   = mw_total;
      resp_before = resp_total;
      send(1'b1, 3'b000, 32'h21, 32'h0000_00AA, mk(32'h0, 1'b0, 4, 1, 1, 8, 32'h0), acc1);
      core.req_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("in_cap_addr", m.mem_address, 32'd8);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("abort");
      q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("abort_no_write", 32'(mw_total - mw_before), 32'd0);
      chk("abort_no_resp", 32'(resp_total - resp_before), 32'd0);
      req(1'b0, 3'b010, 32'h20, 32'h0, mk(32'hCAFE_F00D, 1'b0, 3, 1, 0, 8, 32'h0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
